// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use bubbles, redirect squashes and multi-cycle op freezes,
// plus saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int MD_CYCLES = 4,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_wr_en,
  input  logic             ex_mem_rd_en,
  input  logic             ex_md_op,
  input  logic             ex_redirect,
  input  logic             perf_clr,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic {RUN = 1'b0, MD_WAIT = 1'b1} state_t;

  localparam logic       MD_MULTI = (MD_CYCLES > 1);
  localparam logic [7:0] MD_LOAD  = MD_MULTI ? 8'(MD_CYCLES - 2) : 8'd0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       lu;
  logic       pc_stall_c, if_id_stall_c, if_id_flush_c;
  logic       id_ex_stall_c, id_ex_flush_c, ex_mem_flush_c, md_busy_c;

  assign lu = ex_mem_rd_en & ex_reg_wr_en & (ex_rd != 5'd0) &
              ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pc_stall_c     = 1'b0;
    if_id_stall_c  = 1'b0;
    if_id_flush_c  = 1'b0;
    id_ex_stall_c  = 1'b0;
    id_ex_flush_c  = 1'b0;
    ex_mem_flush_c = 1'b0;
    md_busy_c      = 1'b0;
    case (state_q)
      RUN: begin
        if (ex_redirect) begin
          // The ID instruction is squashed, so a pending load-use match is moot.
          if_id_flush_c = 1'b1;
          id_ex_flush_c = 1'b1;
        end else if (ex_md_op && MD_MULTI) begin
          pc_stall_c     = 1'b1;
          if_id_stall_c  = 1'b1;
          id_ex_stall_c  = 1'b1;
          ex_mem_flush_c = 1'b1;
          md_busy_c      = 1'b1;
          cnt_d          = MD_LOAD;
          state_d        = MD_WAIT;
        end else if (lu) begin
          pc_stall_c    = 1'b1;
          if_id_stall_c = 1'b1;
          id_ex_flush_c = 1'b1;
        end
      end
      MD_WAIT: begin
        if (cnt_q != 8'd0) begin
          pc_stall_c     = 1'b1;
          if_id_stall_c  = 1'b1;
          id_ex_stall_c  = 1'b1;
          ex_mem_flush_c = 1'b1;
          md_busy_c      = 1'b1;
          cnt_d          = cnt_q - 8'd1;
        end else begin
          // Release cycle: the op leaves EX while ex_md_op is still high.
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Reset gates every control output so an aborted op drops them at once.
  assign pc_stall     = pc_stall_c     & rst_n;
  assign if_id_stall  = if_id_stall_c  & rst_n;
  assign if_id_flush  = if_id_flush_c  & rst_n;
  assign id_ex_stall  = id_ex_stall_c  & rst_n;
  assign id_ex_flush  = id_ex_flush_c  & rst_n;
  assign ex_mem_flush = ex_mem_flush_c & rst_n;
  assign md_busy      = md_busy_c      & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else if (perf_clr) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (pc_stall)    stall_cycles <= sat_inc(stall_cycles);
      if (if_id_flush) flush_events <= sat_inc(flush_events);
    end
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller and the control-side producer of the `stall`/`flush` pairs consumed by the IF/ID, ID/EX and EX/MEM pipeline registers. It covers three cases:
- detects load-use hazards between ID and EX and inserts a one-cycle bubble;
- squashes wrong-path instructions on an EX-stage redirect (taken branch, jal, jalr);
- freezes the front of the pipeline while a fixed-latency multi-cycle op (mul/div) occupies EX.

It also keeps saturating stall/flush performance counters.

## Interface
- `MD_CYCLES`, default 4: total EX occupancy of a multi-cycle op, in cycles. Legal range is 1..255.
- `CNT_W`, default 32: width of the performance counters.

- `clk`: in, 1. Single clock, rising edge.
- `rst_n`: in, 1. Reset, asynchronous and active-low.
- `id_rs1`, `id_rs2`: in, 5 each. Source register indices of the instruction in ID.
- `id_use_rs1`, `id_use_rs2`: in, 1 each. The ID instruction actually reads rs1/rs2.
- `ex_rd`: in, 5. Destination register of the instruction in EX.
- `ex_reg_wr_en`: in, 1. The EX instruction writes `ex_rd`.
- `ex_mem_rd_en`: in, 1. The EX instruction is a load.
- `ex_md_op`: in, 1. The EX instruction is a multi-cycle op.
- `ex_redirect`: in, 1. EX resolved a taken branch or a jump.
- `perf_clr`: in, 1. Synchronous clear of both performance counters.
- `pc_stall`: out, 1. Hold the PC.
- `if_id_stall`, `if_id_flush`: out, 1 each. IF/ID register controls.
- `id_ex_stall`, `id_ex_flush`: out, 1 each. ID/EX register controls.
- `ex_mem_flush`: out, 1. Inject a bubble into EX/MEM.
- `md_busy`: out, 1. A multi-cycle op is holding EX.
- `stall_cycles`: out, `CNT_W`. Number of cycles with `pc_stall`=1.
- `flush_events`: out, `CNT_W`. Number of cycles with `if_id_flush`=1.

## Operation
- **State.** FSM with states RUN and MD_WAIT, plus an 8-bit down-counter `cnt`.
- **Outputs.** All control outputs are combinational from the state, `cnt` and the inputs, so they take effect on the same edge.
- **Load-use (`lu`) definition.** `lu` = `ex_mem_rd_en` & `ex_reg_wr_en` & (`ex_rd`≠0) & ((`id_use_rs1` & `id_rs1`==`ex_rd`) | (`id_use_rs2` & `id_rs2`==`ex_rd`)).
- **RUN, priority order:**
  1. `ex_redirect`: `if_id_flush`=1, `id_ex_flush`=1, all stalls 0. This overrides `lu`, because the ID instruction is squashed anyway.
  2. `ex_md_op` with `MD_CYCLES`>1: `pc_stall`=`if_id_stall`=`id_ex_stall`=1, `ex_mem_flush`=1, `md_busy`=1. Load `cnt`<=`MD_CYCLES`-2 and go to MD_WAIT. With `MD_CYCLES`=1 there is no action.
  3. `lu`: `pc_stall`=1, `if_id_stall`=1, `id_ex_flush`=1 (bubble), `id_ex_stall`=0.
  4. Otherwise all outputs are 0.
- **MD_WAIT:**
  - While `cnt`≠0: the same four outputs as the RUN trigger case are asserted, `md_busy`=1, and `cnt` decrements.
  - When `cnt`==0: all outputs are 0 and `md_busy`=0, so the op advances. Next state is RUN.
  - `ex_redirect`, `lu` and `ex_md_op` are ignored in MD_WAIT. `ex_md_op` stays high for the held op and must not retrigger.
- **Total stall.** The pipeline is frozen for exactly `MD_CYCLES`-1 cycles per multi-cycle op.
- **Back-to-back ops.** A new multi-cycle op entering EX on the cycle after release triggers again from RUN.
- **Performance counters:**
  - `stall_cycles` increments on each edge where `pc_stall`=1.
  - `flush_events` increments on each edge where `if_id_flush`=1.
  - Both saturate at all-ones.
  - `perf_clr` takes priority and zeroes both counters on the edge. An event in the same cycle as `perf_clr` is not counted.

## Timing
- **Reset (`rst_n`=0):**
  - State is RUN, `cnt`=0, both counters 0.
  - All control outputs and `md_busy` are gated to 0 regardless of inputs.
- **Reset deassertion.** The FSM becomes active at the first rising edge after `rst_n` goes high.
- **Reset mid-operation.** Reset asserted in MD_WAIT aborts the op immediately and asynchronously. The outputs drop to 0 at once.
- **Latency:**
  - Hazard controls: zero cycles (combinational).
  - FSM and counters: update on the rising edge.
  - Counter outputs reflect an event one cycle later.
- **Load-use bubble.** Exactly one cycle. On the next cycle the load is in MEM, so `lu` is false and forwarding covers the dependency.

## Test plan
- **Load-use:** EX holds a load with `ex_rd`=5, ID has `id_rs1`=5 and `id_use_rs1`=1 → for exactly 1 cycle `pc_stall`=`if_id_stall`=`id_ex_flush`=1 and `id_ex_stall`=0. Then `stall_cycles`=1.
- **No false hazard:** same as the load-use case but `ex_rd`=0, or `id_use_rs1`=0, or `ex_mem_rd_en`=0 → all outputs 0.
- **Redirect vs load-use:** `ex_redirect`=1 together with a load-use match → `if_id_flush`=`id_ex_flush`=1, `pc_stall`=0. Then `flush_events`=1.
- **Multi-cycle op:** `MD_CYCLES`=4 with `ex_md_op` held high → `pc_stall`, `id_ex_stall`, `ex_mem_flush` and `md_busy` high for exactly 3 cycles, 0 on the 4th. Back-to-back ops give a 3+3 stall pattern with a one-cycle gap; `ex_redirect` pulsed during MD_WAIT is ignored.
- **Reset mid-op:** assert `rst_n`=0 on the 2nd stall cycle → all outputs 0 immediately, state RUN after release, counters 0.
- **Saturation and clear:** `CNT_W`=4 with 20 stall cycles → `stall_cycles`=15. Then `perf_clr`=1 for one cycle with a simultaneous stall → 0.
